pipe_stage_reg: RTL and testbench
=================================

PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter CTRL_W, default 11, SHALL set control-field width (WB 2 + Mem 2 + EX 7).
REQ-002 Parameter DATA_W, default 143, SHALL set datapath-field width (PC, Imm, rs1Data, rs2Data: 32 each; rdAddr, rs1Addr, rs2Addr: 5 each).
REQ-003 Parameter SKID, default 1, SHALL select the mode: 1 = two-entry skid with registered in_ready; 0 = single entry with pass-through ready.
REQ-004 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 Reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 in_valid  input  1  SHALL mark the upstream stage as holding a valid instruction.
REQ-007 in_ready  output  1  SHALL accept: a transfer occurs when in_valid && in_ready.
REQ-008 in_ctrl  input  CTRL_W  SHALL carry the upstream control bundle.
REQ-009 in_data  input  DATA_W  SHALL carry the upstream datapath bundle.
REQ-010 out_valid  output  1  SHALL mark the downstream stage as holding a valid instruction.
REQ-011 out_ready  input  1  SHALL be the downstream accept; a transfer occurs when out_valid && out_ready.
REQ-012 out_ctrl  output  CTRL_W  SHALL carry the control bundle of the head entry.
REQ-013 out_data  output  DATA_W  SHALL carry the datapath bundle of the head entry.
REQ-014 flush  input  1  SHALL discard all held entries (branch mispredict or exception).
REQ-015 bubble_cnt  output  16  SHALL count cycles in which out_ready=1 and out_valid=0.

Function
REQ-016 State SHALL be one of EMPTY (0 entries), FULL (head only) or SKID (head + skid); SKID is unreachable when SKID=0.
REQ-017 From EMPTY, an accepted input SHALL move the state to FULL, with the head loaded from in_ctrl/in_data.
REQ-018 In FULL, an accept together with a downstream take SHALL reload the head and keep FULL; a take alone SHALL go to EMPTY; with SKID=1, an accept alone SHALL load the skid entry and go to SKID.
REQ-019 In SKID, a downstream take SHALL move the skid entry into the head and go to FULL; no input SHALL be accepted while in SKID.
REQ-020 With SKID=1, in_ready SHALL be a registered value, 1 in EMPTY and FULL and 0 in SKID.
REQ-021 With SKID=0, in_ready SHALL equal out_ready || !out_valid (combinational).
REQ-022 Latency from input accept to out_valid SHALL be exactly 1 cycle; ordering SHALL be strictly FIFO.
REQ-023 out_valid SHALL be 1 in FULL and SKID, and 0 in EMPTY.
REQ-024 out_ctrl SHALL be forced to all-zero whenever out_valid=0 (bubble = NOP: no RegWrite, no MemRead/MemWrite).
REQ-025 out_data SHALL hold its last value when out_valid=0; no zeroing is required.
REQ-026 Flush SHALL take priority over every transfer: the next state SHALL be EMPTY, and an input presented in the flush cycle SHALL be dropped even if in_ready=1.
REQ-027 The cycle after a flush, out_valid SHALL be 0, out_ctrl SHALL be 0, and in_ready SHALL be 1.
REQ-028 bubble_cnt SHALL saturate at 16'hFFFF and SHALL NOT wrap.
REQ-029 Holding out_ready=0 SHALL keep out_ctrl and out_data stable (stall), with no entry lost or duplicated.

Reset
REQ-030 Reset_n low SHALL asynchronously force state EMPTY, out_valid=0, out_ctrl=0, out_data=0 and bubble_cnt=0.
REQ-031 Reset_n low SHALL force in_ready=1 when SKID=1; in_ready SHALL follow REQ-021 when SKID=0.
REQ-032 Reset asserted mid-operation SHALL discard both entries; after release, the first accepted input SHALL appear on out_ctrl/out_data one cycle after its accept.

Structure
REQ-033 The shared package SHALL hold the state enum (EMPTY/FULL/SKID), the default CTRL_W/DATA_W constants and the WB/Mem/EX field offsets within the control bundle.
REQ-034 The block SHALL instantiate one sub-module, pipe_entry (a payload register with load enable and asynchronous clear), once for the head and, when SKID=1, once for the skid.

Verification
REQ-035 The bench SHALL cover these scenarios:
- Reset, then in_valid=1, in_ctrl=11'h7FF, in_data=A, out_ready=1 -> out_valid=1, out_ctrl=11'h7FF, out_data=A the next cycle.
- SKID=1, three back-to-back inputs A, B, C with out_ready=0 -> A accepted, B into skid, in_ready=0, C held; release out_ready -> outputs A, B, C in order, no duplicates.
- FULL with A plus a pending input B, flush=1 -> next cycle out_valid=0, out_ctrl=0, B never appears.
- out_ready=1 with no input for 70000 cycles -> bubble_cnt=16'hFFFF and stays there.
- Reset_n pulsed low mid-stream in the SKID state -> out_valid=0 immediately (asynchronous), in_ready=1, and the next input passes with 1-cycle latency.
- SKID=0, out_ready=0 while FULL -> in_ready=0 combinationally; raise out_ready -> in_ready=1 in the same cycle, and the simultaneous take and accept keep the state FULL.

Source files
------------

// File: rtl/pipe_stage_reg_pkg.sv
// Shared types and constants for the ID/EX pipeline register.
// Control bundle layout: {WB[1:0], MEM[1:0], EX[6:0]}.
package pipe_stage_reg_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } stage_st_e;

  localparam int CTRL_W_DEF = 11;
  localparam int DATA_W_DEF = 143;

  localparam int EX_LSB  = 0;
  localparam int EX_W    = 7;
  localparam int MEM_LSB = 7;
  localparam int MEM_W   = 2;
  localparam int WB_LSB  = 9;
  localparam int WB_W    = 2;

endpackage

// File: rtl/pipe_entry.sv
// Payload register with load enable.
// Cleared asynchronously so a reset never leaks stale data.
module pipe_entry #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         Reset_n,
  input  logic         ld,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // hold payload until loaded
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) q <= '0;
    else if (ld)  q <= d;
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline register between decode and execute.
// Optional skid entry lets in_ready come straight from a flop.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              Reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  output logic [15:0]       bubble_cnt
);

  localparam int W = CTRL_W + DATA_W;

  stage_st_e    st_q, st_d;
  logic         fire_in, take;
  logic         head_ld, skid_ld;
  logic [W-1:0] in_pl, head_d, head_q, skid_q;

  assign in_pl     = {in_ctrl, in_data};
  assign fire_in   = in_valid && in_ready && !flush;
  assign out_valid = (st_q != ST_EMPTY);
  assign take      = out_valid && out_ready;

  // next state and entry load enables; flush overrides all
  always_comb begin
    st_d    = st_q;
    head_ld = 1'b0;
    skid_ld = 1'b0;
    head_d  = in_pl;
    unique case (st_q)
      ST_EMPTY: begin
        if (fire_in) begin
          st_d    = ST_FULL;
          head_ld = 1'b1;
        end
      end
      ST_FULL: begin
        if (fire_in && take) begin
          head_ld = 1'b1;
        end else if (take) begin
          st_d = ST_EMPTY;
        end else if (fire_in && SKID != 0) begin
          st_d    = ST_SKID;
          skid_ld = 1'b1;
        end
      end
      ST_SKID: begin
        if (take) begin
          st_d    = ST_FULL;
          head_ld = 1'b1;
          head_d  = skid_q;
        end
      end
      default: st_d = ST_EMPTY;
    endcase
    if (flush) begin
      st_d    = ST_EMPTY;
      head_ld = 1'b0;
      skid_ld = 1'b0;
    end
  end

  // occupancy state
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) st_q <= ST_EMPTY;
    else          st_q <= st_d;
  end

  pipe_entry #(.W(W)) u_head (
    .clk     (clk),
    .Reset_n (Reset_n),
    .ld      (head_ld),
    .d       (head_d),
    .q       (head_q)
  );

  generate
    if (SKID != 0) begin : g_skid
      logic rdy_q;

      // ready is low only while the skid slot is occupied
      always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) rdy_q <= 1'b1;
        else          rdy_q <= (st_d != ST_SKID);
      end

      assign in_ready = rdy_q;

      pipe_entry #(.W(W)) u_skid (
        .clk     (clk),
        .Reset_n (Reset_n),
        .ld      (skid_ld),
        .d       (in_pl),
        .q       (skid_q)
      );
    end else begin : g_pass
      logic unused_skid_ld;
      assign unused_skid_ld = skid_ld;
      assign in_ready = out_ready || !out_valid;
      assign skid_q   = '0;
    end
  endgenerate

  // bubbles issue as NOPs: no write-back, no memory access
  assign out_ctrl = out_valid ? head_q[W-1 -: CTRL_W] : '0;
  assign out_data = head_q[DATA_W-1:0];

  // saturating count of starved downstream cycles
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n)
      bubble_cnt <= '0;
    else if (out_ready && !out_valid && bubble_cnt != 16'hFFFF)
      bubble_cnt <= bubble_cnt + 16'd1;
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: skid and pass-through builds side by side,
// checked against queue-based occupancy models.
module tb_pipe_stage_reg;

  localparam int CW = 11;
  localparam int DW = 143;
  typedef logic [CW+DW-1:0] ent_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [CW-1:0] in_ctrl = '0;
  logic [DW-1:0] in_data = '0;
  logic          out_ready = 1'b0;
  logic          flush = 1'b0;

  logic          r1, ov1, r0, ov0;
  logic [CW-1:0] oc1, oc0;
  logic [DW-1:0] od1, od0;
  logic [15:0]   bc1, bc0;

  int total = 0;
  int bad = 0;

  ent_t m1[$];
  ent_t m0[$];
  int   b1 = 0;
  int   b0 = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(1)) dut1 (
    .clk(clk), .Reset_n(rst_n),
    .in_valid(in_valid), .in_ready(r1),
    .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(ov1), .out_ready(out_ready),
    .out_ctrl(oc1), .out_data(od1),
    .flush(flush), .bubble_cnt(bc1)
  );

  pipe_stage_reg #(.CTRL_W(CW), .DATA_W(DW), .SKID(0)) dut0 (
    .clk(clk), .Reset_n(rst_n),
    .in_valid(in_valid), .in_ready(r0),
    .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(ov0), .out_ready(out_ready),
    .out_ctrl(oc0), .out_data(od0),
    .flush(flush), .bubble_cnt(bc0)
  );

  function automatic logic [DW-1:0] rnd_d();
    logic [159:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return t[DW-1:0];
  endfunction

  // advance both models by one clock, then sample point
  task automatic step();
    ent_t x;
    x = {in_ctrl, in_data};
    if (rst_n) begin
      if (out_ready && m1.size() == 0 && b1 < 65535) b1++;
      if (out_ready && m0.size() == 0 && b0 < 65535) b0++;
      if (flush) begin
        m1.delete();
        m0.delete();
      end else begin
        bit a1, a0;
        a1 = in_valid && m1.size() < 2;
        a0 = in_valid && (out_ready || m0.size() == 0);
        if (out_ready && m1.size() > 0) void'(m1.pop_front());
        if (out_ready && m0.size() > 0) void'(m0.pop_front());
        if (a1) m1.push_back(x);
        if (a0) m0.push_back(x);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m1.delete();
    m0.delete();
    b1 = 0;
    b0 = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    #12;
    total++;
    if (ov1 !== 1'b0) begin
      bad++; $display("FAIL rst_valid got=%b exp=0", ov1);
    end
    total++;
    if (oc1 !== '0 || od1 !== '0) begin
      bad++; $display("FAIL rst_payload got=%h/%h exp=0", oc1, od1);
    end
    total++;
    if (bc1 !== 16'd0 || bc0 !== 16'd0) begin
      bad++; $display("FAIL rst_bubble got=%h/%h exp=0", bc1, bc0);
    end
    total++;
    if (r1 !== 1'b1 || r0 !== 1'b1) begin
      bad++; $display("FAIL rst_ready got=%b%b exp=11", r1, r0);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_pass();
    logic [DW-1:0] a;
    a = rnd_d();
    in_valid = 1'b1;
    in_ctrl = 11'h7FF;
    in_data = a;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    total++;
    if (ov1 !== 1'b1 || oc1 !== 11'h7FF || od1 !== a) begin
      bad++; $display("FAIL pass_skid got=%b/%h/%h exp=1/7ff/%h", ov1, oc1, od1, a);
    end
    total++;
    if (ov0 !== 1'b1 || oc0 !== 11'h7FF || od0 !== a) begin
      bad++; $display("FAIL pass_noskid got=%b/%h/%h exp=1/7ff/%h", ov0, oc0, od0, a);
    end
    step();
    total++;
    if (ov1 !== 1'b0 || oc1 !== '0) begin
      bad++; $display("FAIL pass_drain got=%b/%h exp=0/0", ov1, oc1);
    end
  endtask

  task automatic test_skid();
    logic [DW-1:0] a, b, c;
    a = rnd_d();
    b = rnd_d();
    c = rnd_d();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_ctrl = 11'h101;
    in_data = a;
    step();
    total++;
    if (ov1 !== 1'b1 || od1 !== a || r1 !== 1'b1) begin
      bad++; $display("FAIL skid_a got=%b/%h/%b exp=1/%h/1", ov1, od1, r1, a);
    end
    in_ctrl = 11'h102;
    in_data = b;
    step();
    total++;
    if (r1 !== 1'b0 || oc1 !== 11'h101 || od1 !== a) begin
      bad++; $display("FAIL skid_full got=%b/%h/%h exp=0/101/%h", r1, oc1, od1, a);
    end
    in_ctrl = 11'h103;
    in_data = c;
    step();
    total++;
    if (r1 !== 1'b0 || od1 !== a) begin
      bad++; $display("FAIL skid_stall got=%b/%h exp=0/%h", r1, od1, a);
    end
    out_ready = 1'b1;
    step();
    total++;
    if (ov1 !== 1'b1 || oc1 !== 11'h102 || od1 !== b || r1 !== 1'b1) begin
      bad++; $display("FAIL skid_b got=%b/%h/%h/%b exp=1/102/%h/1", ov1, oc1, od1, r1, b);
    end
    step();
    in_valid = 1'b0;
    total++;
    if (ov1 !== 1'b1 || oc1 !== 11'h103 || od1 !== c) begin
      bad++; $display("FAIL skid_c got=%b/%h/%h exp=1/103/%h", ov1, oc1, od1, c);
    end
    step();
    total++;
    if (ov1 !== 1'b0) begin
      bad++; $display("FAIL skid_nodup got=%b exp=0", ov1);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_ctrl = 11'h3C5;
    in_data = rnd_d();
    step();
    in_ctrl = 11'h2A7;
    in_data = rnd_d();
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    total++;
    if (ov1 !== 1'b0 || oc1 !== '0 || r1 !== 1'b1) begin
      bad++; $display("FAIL flush_skid got=%b/%h/%b exp=0/0/1", ov1, oc1, r1);
    end
    total++;
    if (ov0 !== 1'b0 || oc0 !== '0 || r0 !== 1'b1) begin
      bad++; $display("FAIL flush_noskid got=%b/%h/%b exp=0/0/1", ov0, oc0, r0);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if (ov1 !== 1'b0 || ov0 !== 1'b0) begin
        bad++; $display("FAIL flush_drop got=%b%b exp=00", ov1, ov0);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] d;
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = rnd_d();
    in_ctrl = 11'h011;
    step();
    in_data = rnd_d();
    in_ctrl = 11'h022;
    step();
    total++;
    if (r1 !== 1'b0) begin
      bad++; $display("FAIL rmid_inskid got=%b exp=0", r1);
    end
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    total++;
    if (ov1 !== 1'b0 || oc1 !== '0 || r1 !== 1'b1) begin
      bad++; $display("FAIL rmid_async got=%b/%h/%b exp=0/0/1", ov1, oc1, r1);
    end
    #2;
    rst_n = 1'b1;
    d = rnd_d();
    in_valid = 1'b1;
    in_ctrl = 11'h455;
    in_data = d;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    total++;
    if (ov1 !== 1'b1 || oc1 !== 11'h455 || od1 !== d) begin
      bad++; $display("FAIL rmid_next got=%b/%h/%h exp=1/455/%h", ov1, oc1, od1, d);
    end
    step();
  endtask

  task automatic test_noskid();
    logic [DW-1:0] b;
    b = rnd_d();
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_ctrl = 11'h0F0;
    in_data = rnd_d();
    step();
    in_ctrl = 11'h00F;
    in_data = b;
    #1;
    total++;
    if (r0 !== 1'b0) begin
      bad++; $display("FAIL nosk_stall got=%b exp=0", r0);
    end
    out_ready = 1'b1;
    #1;
    total++;
    if (r0 !== 1'b1) begin
      bad++; $display("FAIL nosk_comb got=%b exp=1", r0);
    end
    step();
    in_valid = 1'b0;
    total++;
    if (ov0 !== 1'b1 || oc0 !== 11'h00F || od0 !== b) begin
      bad++; $display("FAIL nosk_swap got=%b/%h/%h exp=1/00f/%h", ov0, oc0, od0, b);
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic test_random();
    ent_t h1, h0;
    logic e1, e0;
    for (int i = 0; i < 400; i++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 15) == 0);
      in_ctrl = CW'($urandom);
      in_data = rnd_d();
      #1;
      e1 = (m1.size() > 0);
      e0 = (m0.size() > 0);
      h1 = e1 ? m1[0] : '0;
      h0 = e0 ? m0[0] : '0;
      total++;
      if (ov1 !== e1 || oc1 !== h1[CW+DW-1:DW]) begin
        bad++; $display("FAIL rnd_head1 c%0d got=%b/%h exp=%b/%h", i, ov1, oc1, e1, h1[CW+DW-1:DW]);
      end
      total++;
      if (e1 && od1 !== h1[DW-1:0]) begin
        bad++; $display("FAIL rnd_data1 c%0d got=%h exp=%h", i, od1, h1[DW-1:0]);
      end
      total++;
      if (r1 !== (m1.size() < 2)) begin
        bad++; $display("FAIL rnd_rdy1 c%0d got=%b exp=%b", i, r1, m1.size() < 2);
      end
      total++;
      if (ov0 !== e0 || oc0 !== h0[CW+DW-1:DW]) begin
        bad++; $display("FAIL rnd_head0 c%0d got=%b/%h exp=%b/%h", i, ov0, oc0, e0, h0[CW+DW-1:DW]);
      end
      total++;
      if (e0 && od0 !== h0[DW-1:0]) begin
        bad++; $display("FAIL rnd_data0 c%0d got=%h exp=%h", i, od0, h0[DW-1:0]);
      end
      total++;
      if (r0 !== (out_ready || !e0)) begin
        bad++; $display("FAIL rnd_rdy0 c%0d got=%b exp=%b", i, r0, out_ready || !e0);
      end
      total++;
      if (int'(bc1) != b1 || int'(bc0) != b0) begin
        bad++; $display("FAIL rnd_bubble c%0d got=%0d/%0d exp=%0d/%0d", i, bc1, bc0, b1, b0);
      end
      step();
    end
    flush = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic test_bubble_sat();
    rst_n = 1'b0;
    model_reset();
    in_valid = 1'b0;
    flush = 1'b0;
    out_ready = 1'b1;
    #3;
    rst_n = 1'b1;
    for (int i = 0; i < 70000; i++) step();
    total++;
    if (bc1 !== 16'hFFFF || bc0 !== 16'hFFFF || b1 != 65535) begin
      bad++; $display("FAIL bub_sat got=%h/%h exp=ffff", bc1, bc0);
    end
    for (int i = 0; i < 20; i++) step();
    total++;
    if (bc1 !== 16'hFFFF || bc0 !== 16'hFFFF) begin
      bad++; $display("FAIL bub_nowrap got=%h/%h exp=ffff", bc1, bc0);
    end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_skid();
    test_flush();
    test_reset_mid();
    test_noskid();
    test_random();
    test_bubble_sat();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
